uart_tx: RTL and testbench

Serial transmitter for the UART_ALU datapath. It accepts a parallel word on a single-cycle start strobe and drives an idle-high, LSB-first asynchronous frame on `tx`: one start bit, the data bits, an optional parity bit, then one stop bit. Each bit is held for a fixed number of `clk` cycles. The default timing matches the UART_RX block, which uses a 16-count bit period and samples at count 8, so a `tx`→`rx` loopback works without glue logic.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_bit_timer.sv | 31 +++
 rtl/uart_tx.sv | 145 ++++++++++++++
 tb/tb_uart_tx.sv | 130 +++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and FSM state encoding, used by both transmitter and receiver.
// Parity state only exists when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 16;
  localparam int SAMPLE_POINT     = 8;

`ifdef UART_TX_PARITY_EN
  localparam int STATE_W = 3;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } uart_state_e;
`else
  localparam int STATE_W = 2;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;
`endif

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts CLKS_PER_BIT cycles while enabled and pulses wrap on the last one.
// Shared between transmitter and receiver.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic wrap
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_r;

  assign wrap = en && (cnt_r == LAST);

  // Period counter, restarted on clear and on every wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clr || wrap) begin
      cnt_r <= '0;
    end else if (en) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: idle-high, LSB-first frame of start, data, optional parity, stop bit.
// Define UART_TX_PARITY_EN to insert the parity bit (PARITY_ODD selects odd parity).
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_LENGTH  = 8,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int PARITY_ODD   = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DATA_LENGTH-1:0] data_i,
  output logic                   tx,
  output logic                   busy,
  output logic                   done
);

  localparam int CNT_W = (DATA_LENGTH > 1) ? $clog2(DATA_LENGTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_LENGTH - 1);

  uart_state_e            state_r, state_nxt_s;
  logic [DATA_LENGTH-1:0] shift_r;
  logic [CNT_W-1:0]       bit_cnt_r;
  logic                   wrap_s, last_bit_s;
  logic                   tx_s, busy_s;
  logic                   tx_r, busy_r, frame_end_r, done_r;
`ifdef UART_TX_PARITY_EN
  logic                   parity_r;
`endif

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_r == IDLE),
    .en   (state_r != IDLE),
    .wrap (wrap_s)
  );

  assign last_bit_s = (bit_cnt_r == LAST_BIT);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and pre-register line/busy values
  always_comb begin
    state_nxt_s = state_r;
    tx_s        = 1'b1;
    busy_s      = 1'b1;
    case (state_r)
      IDLE: begin
        busy_s = 1'b0;
        if (start) state_nxt_s = START;
        else       state_nxt_s = IDLE;
      end
      START: begin
        tx_s = 1'b0;
        if (wrap_s) state_nxt_s = DATA;
        else        state_nxt_s = START;
      end
      DATA: begin
        tx_s = shift_r[0];
`ifdef UART_TX_PARITY_EN
        if (wrap_s && last_bit_s) state_nxt_s = PARITY;
`else
        if (wrap_s && last_bit_s) state_nxt_s = STOP;
`endif
        else                      state_nxt_s = DATA;
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_s = parity_r;
        if (wrap_s) state_nxt_s = STOP;
        else        state_nxt_s = PARITY;
      end
`endif
      STOP: begin
        tx_s = 1'b1;
        if (wrap_s) state_nxt_s = IDLE;
        else        state_nxt_s = STOP;
      end
      default: begin
        busy_s      = 1'b0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Word capture at accept, shift-out and bit counting during DATA
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_r   <= '0;
      bit_cnt_r <= '0;
`ifdef UART_TX_PARITY_EN
      parity_r  <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          bit_cnt_r <= '0;
          if (start) begin
            shift_r  <= data_i;
`ifdef UART_TX_PARITY_EN
            parity_r <= (^data_i) ^ PARITY_ODD[0];
`endif
          end
        end
        DATA: begin
          if (wrap_s) begin
            shift_r <= shift_r >> 1;
            if (!last_bit_s) bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            else             bit_cnt_r <= '0;
          end
        end
        default: bit_cnt_r <= '0;
      endcase
    end
  end

  // Registered outputs; done trails the STOP->IDLE edge by one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_r        <= 1'b1;
      busy_r      <= 1'b0;
      frame_end_r <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      tx_r        <= tx_s;
      busy_r      <= busy_s;
      frame_end_r <= (state_r == STOP) && wrap_s;
      done_r      <= frame_end_r;
    end
  end

  assign tx   = tx_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: default 8-bit/16-clock instance plus a 5-bit/4-clock instance,
// compared cycle by cycle against a frame model built as a queue of expected line bits.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic [7:0] data_a = 8'h00;
  logic [4:0] data_b = 5'h00;
  logic       tx_a, busy_a, done_a;
  logic       tx_b, busy_b, done_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .data_i(data_a),
    .tx(tx_a), .busy(busy_a), .done(done_a)
  );

  uart_tx #(.DATA_LENGTH(5), .CLKS_PER_BIT(4)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .data_i(data_b),
    .tx(tx_b), .busy(busy_b), .done(done_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_line(input string tag, input bit inst, input logic etx, input logic ebusy,
                          input logic edone);
    chk({tag, "_tx"},   inst ? tx_b   : tx_a,   etx);
    chk({tag, "_busy"}, inst ? busy_b : busy_a, ebusy);
    chk({tag, "_done"}, inst ? done_b : done_a, edone);
  endtask

  // Send one frame on instance inst and check every cycle. abort_j>0 asserts rst at that cycle.
  task automatic frame(input logic [7:0] d, input bit inst, input bit mid_start, input int abort_j);
    int n, c, f;
    bit q[$];
    n = inst ? 5 : 8;
    c = inst ? 4 : 16;
    q.push_back(1'b0);
    for (int i = 0; i < n; i++) q.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    begin
      bit p;
      p = 1'b0;
      for (int i = 0; i < n; i++) p ^= d[i];
      q.push_back(p);
    end
`endif
    q.push_back(1'b1);
    f = q.size() * c;

    if (inst) begin start_b = 1'b1; data_b = d[4:0]; end
    else      begin start_a = 1'b1; data_a = d;      end
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    for (int j = 1; j <= f + 1; j++) begin
      @(posedge clk);
      @(negedge clk);
      if (j == f + 1) begin
        chk_line("end", inst, 1'b1, 1'b0, 1'b1);
      end else begin
        chk_line("bit", inst, q[(j - 1) / c], 1'b1, 1'b0);
      end
      if (abort_j != 0 && j == abort_j) begin
        rst = 1'b1;
        #1;
        chk_line("abort", inst, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (mid_start && j == 60) begin
        if (inst) begin start_b = 1'b1; data_b = 5'h1F; end
        else      begin start_a = 1'b1; data_a = 8'hFF; end
      end else begin
        start_a = 1'b0;
        start_b = 1'b0;
      end
    end
  endtask

  task automatic idle_check(input string tag, input int cycles);
    for (int j = 0; j < cycles; j++) begin
      @(negedge clk);
      chk_line(tag, 1'b0, 1'b1, 1'b0, 1'b0);
      chk_line(tag, 1'b1, 1'b1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_line("rst", 1'b0, 1'b1, 1'b0, 1'b0);
    chk_line("rst", 1'b1, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    idle_check("idle", 50);

    frame(8'hA5, 1'b0, 1'b0, 0);
    frame(8'h3C, 1'b0, 1'b1, 0);
    idle_check("gap", 5);

    // Abort during data bit 4 of 8'h0F, then no done and a clean frame follows
    frame(8'h0F, 1'b0, 1'b0, 1 + 5 * 16 + 3);
    idle_check("post_abort", 200);
    frame(8'h81, 1'b0, 1'b0, 0);

    for (int r = 0; r < 4; r++) frame(8'($urandom_range(0, 255)), 1'b0, r[0], 0);
    idle_check("gap2", 3);

    frame(8'h15, 1'b1, 1'b0, 0);
    frame(8'h0A, 1'b1, 1'b0, 0);
    for (int r = 0; r < 3; r++) frame(8'($urandom_range(0, 31)), 1'b1, 1'b0, 0);
    idle_check("final", 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
